channel_fetch_scheduler: RTL and testbench
==========================================

# channel_fetch_scheduler

Sequences per-sample delta fetches for all audio channels of the audiosystem. On every rising `lrclk` edge it walks the channels in index order, reads one 12-bit sample delta per active channel from sample memory through a single shared request/acknowledge port, and holds each result on that channel's `i_sampleDelta` input until the next frame. It sits between the channel array and the sample-memory arbiter. It is the only block that drives channel deltas.

## Interface
- `NUM_CHANNELS`, default 8: number of channels served, 1..16.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `lrclk`  in  1: frame clock, synchronous to `clk`; the rising edge starts a fetch sequence.
- `i_chanAddr`  in  32*NUM_CHANNELS: next-sample address of channel k at bits [32k+31:32k].
- `i_chanActive`  in  NUM_CHANNELS: bit k high means channel k is playing.
- `o_memReq`  out  1: memory read request.
- `o_memAddr`  out  32: read address, registered.
- `i_memAck`  in  1: read data valid / request accepted.
- `i_memData`  in  16: read data; only bits [11:0] are used.
- `o_sampleDelta`  out  12*NUM_CHANNELS: delta for channel k at bits [12k+11:12k], registered.
- `o_busy`  out  1: high in every state except IDLE.
- `o_overrun`  out  1: sticky; set when a frame edge arrives while busy.
- `i_clearOverrun`  in  1: clears `o_overrun`.

## Operation
- Edge detect: `edge = lrclk & ~lrclk_q`. `lrclk_q` is registered every cycle and resets to 1, so `lrclk` already high at reset release is not an edge.
- Channel counter `ch` is `$clog2(NUM_CHANNELS+1)` bits wide.
- States:
  - IDLE: on `edge`, go to SETTLE.
  - SETTLE: lasts one cycle. Channel positions update on the same edge, so addresses are stable here. Set `ch`=0 and go to SCAN.
  - SCAN, channel active (`i_chanActive[ch]`=1): `o_memAddr`<=slice `ch` of `i_chanAddr`, `o_memReq`<=1, go to REQ.
  - SCAN, channel inactive: delta[`ch`]<=0, `ch`++. Stay in SCAN, or leave it if `ch` was NUM_CHANNELS-1.
  - REQ: hold `o_memReq`=1 and `o_memAddr` stable until `i_memAck`. On the ack cycle: delta[`ch`]<=`i_memData[11:0]`, `o_memReq`<=0, `ch`++, go to SCAN, or leave it if this was the last channel.
  - Leaving after the last channel: go to SETTLE if `pending` is set (clear `pending`), else go to IDLE.
- `i_memAck` is ignored while `o_memReq`=0. `o_memReq` is never high in two consecutive fetches without an intervening low cycle.
- Overrun:
  - `edge` in any state other than IDLE sets `o_overrun` and `pending`. The current sequence completes; no outstanding request is ever abandoned.
  - Multiple edges while busy collapse into one `pending`.
  - `i_clearOverrun` and a setting edge in the same cycle: set wins.
- Deltas are latched raw. Sign extension is the channel's job.
- `i_chanActive` is sampled per channel in SCAN only; changes after that take effect next frame.

## Timing
- Reset values: `o_memReq`=0, `o_memAddr`=0, all deltas=0, `o_busy`=0, `o_overrun`=0, state IDLE, `pending`=0, `ch`=0.
- Asserting `rst` mid-request drops `o_memReq` immediately. The memory side must tolerate an abandoned request.
- Edge sampled in cycle E: SETTLE in E+1, first SCAN in E+2. First `o_memReq` is high from E+3.
- Zero-wait memory (ack in first REQ cycle): 2 cycles per active channel, 1 per inactive channel.
- Full sequence: 1 (SETTLE) + 2*active + inactive cycles, then IDLE. Each wait state adds 1 cycle.
- Delta k is visible on `o_sampleDelta` the cycle after its ack. It must be valid before the next rising `lrclk`, otherwise an overrun is flagged.

## Test plan
- All 4 channels active, ack same cycle, data 0x0ABC/0x0123/0x0FFF/0x0800:
  - deltas equal the data values;
  - `o_memReq` high on E+3, E+5, E+7, E+9;
  - `o_busy` falls after E+9;
  - addresses match each channel's slice.
- Channel 1 ack delayed 3 cycles: `o_memReq` and `o_memAddr` stable for 4 cycles, then deltas for 2 and 3 fetched normally.
- `i_chanActive`=4'b0101 with deltas preloaded 0x555: deltas 1 and 3 become 0; exactly 2 requests issued; sequence lasts 7 cycles.
- Second edge while channel 2 is in REQ with ack stalled:
  - `o_overrun`=1;
  - after channel 3 completes, SETTLE then refetch from channel 0;
  - `i_clearOverrun` clears `o_overrun`;
  - with a simultaneous edge, `o_overrun` stays set.
- `i_memData`=0xF7FF: delta is 0x7FF.
- Reset asserted while in REQ, with `lrclk` held high through release:
  - `o_memReq` drops without a clock edge;
  - all outputs return to 0;
  - no request after release until the next real rising edge.

Source files
------------

// File: rtl/channel_fetch_scheduler.sv
// Per-frame sample-delta fetch sequencer: on each rising lrclk it walks the channels in order,
// reads one 12-bit delta per active channel over a shared req/ack port and holds it until the next frame.
module channel_fetch_scheduler #(
  parameter int NUM_CHANNELS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lrclk,
  input  logic [32*NUM_CHANNELS-1:0]  i_chanAddr,
  input  logic [NUM_CHANNELS-1:0]     i_chanActive,
  output logic                        o_memReq,
  output logic [31:0]                 o_memAddr,
  input  logic                        i_memAck,
  input  logic [15:0]                 i_memData,
  output logic [12*NUM_CHANNELS-1:0]  o_sampleDelta,
  output logic                        o_busy,
  output logic                        o_overrun,
  input  logic                        i_clearOverrun
);

  localparam int            CW      = $clog2(NUM_CHANNELS + 1);
  localparam int            NSLOT   = 1 << CW;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);
  localparam logic [CW-1:0] ONE_CH  = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_REQ    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          lrclk_q;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic          busy_q;
  logic [11:0]   delta_q [NUM_CHANNELS];
  logic [11:0]   delta_d [NUM_CHANNELS];

  logic          edge_s, last_s, ack_s, done_s, dwr_s;
  logic [11:0]   dval_s;
  logic          mem_data_unused_s;

  // Channel views padded to a power of two so the counter indexes them at its natural width.
  logic [31:0]   addr_s   [NSLOT];
  logic          active_s [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < NUM_CHANNELS) begin : g_used
      assign addr_s[k]   = i_chanAddr[32*k +: 32];
      assign active_s[k] = i_chanActive[k];
      assign o_sampleDelta[12*k +: 12] = delta_q[k];
    end else begin : g_pad
      assign addr_s[k]   = 32'h0000_0000;
      assign active_s[k] = 1'b0;
    end
  end

  assign mem_data_unused_s = ^i_memData[15:12];
  assign edge_s = lrclk & ~lrclk_q;
  assign last_s = (ch_q == LAST_CH);
  assign ack_s  = i_memAck & req_q;

  // Sequencer next-state; an edge arriving on the final step is consumed directly as the restart.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pending_d = pending_q;
    req_d     = req_q;
    addr_d    = addr_q;
    done_s    = 1'b0;
    dwr_s     = 1'b0;
    dval_s    = 12'h000;
    case (state_q)
      S_IDLE: begin
        if (edge_s) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        ch_d    = {CW{1'b0}};
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (active_s[ch_q]) begin
          addr_d  = addr_s[ch_q];
          req_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          dwr_s  = 1'b1;
          dval_s = 12'h000;
          ch_d   = ch_q + ONE_CH;
          done_s = last_s;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          dwr_s   = 1'b1;
          dval_s  = i_memData[11:0];
          req_d   = 1'b0;
          ch_d    = ch_q + ONE_CH;
          state_d = S_SCAN;
          done_s  = last_s;
        end else begin
          req_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (done_s) begin
      if (pending_q || edge_s) begin
        state_d   = S_SETTLE;
        pending_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (edge_s && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Sticky overrun: a busy-time edge beats a same-cycle clear.
  always_comb begin
    if (edge_s && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (i_clearOverrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Delta write-back to the channel currently addressed by the counter.
  always_comb begin
    delta_d = delta_q;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (dwr_s && (ch_q == CW'(k))) begin
        delta_d[k] = dval_s;
      end else begin
        delta_d[k] = delta_q[k];
      end
    end
  end

  // State registers; lrclk_q resets high so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ch_q      <= {CW{1'b0}};
      lrclk_q   <= 1'b1;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= 32'h0000_0000;
      busy_q    <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        delta_q[k] <= 12'h000;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      lrclk_q   <= lrclk;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      busy_q    <= (state_d != S_IDLE);
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        delta_q[k] <= delta_d[k];
      end
    end
  end

  assign o_memReq  = req_q;
  assign o_memAddr = addr_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_channel_fetch_scheduler.sv
// Bench for channel_fetch_scheduler: builds a per-cycle timeline of expected bus activity from the
// frame rules (settle, scan, request+waits per channel) and acts as the acknowledging memory.
module tb_channel_fetch_scheduler;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              lrclk;
  logic [31:0]       addr [NCH];
  logic [32*NCH-1:0] i_chanAddr;
  logic [NCH-1:0]    i_chanActive;
  logic              o_memReq;
  logic [31:0]       o_memAddr;
  logic              i_memAck;
  logic [15:0]       i_memData;
  logic [12*NCH-1:0] o_sampleDelta;
  logic              o_busy;
  logic              o_overrun;
  logic              i_clearOverrun;

  always #5 clk = ~clk;
  assign i_chanAddr = {addr[3], addr[2], addr[1], addr[0]};

  channel_fetch_scheduler #(.NUM_CHANNELS(NCH)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk), .i_chanAddr(i_chanAddr), .i_chanActive(i_chanActive),
    .o_memReq(o_memReq), .o_memAddr(o_memAddr), .i_memAck(i_memAck), .i_memData(i_memData),
    .o_sampleDelta(o_sampleDelta), .o_busy(o_busy), .o_overrun(o_overrun),
    .i_clearOverrun(i_clearOverrun)
  );

  int          vectors = 0;
  int          errors  = 0;
  logic [11:0] cur_delta [NCH];
  logic        ov_exp;
  logic [3:0]  fm;
  int          fw [2][NCH];
  logic [15:0] fd [2][NCH];

  bit          tl_req  [$];
  logic [31:0] tl_addr [$];
  int          tl_zero [$];
  int          fch     [$];
  int          fwait   [$];
  logic [15:0] fdata   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_deltas(input string tag);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("%s_d%0d", tag, k), {20'h0, o_sampleDelta[12*k +: 12]}, {20'h0, cur_delta[k]});
  endtask

  // Timeline of one frame: settle, then per channel one scan cycle plus (1+wait) request cycles if active.
  function automatic void add_frame(input int f);
    tl_req.push_back(1'b0); tl_addr.push_back(32'h0); tl_zero.push_back(-1);
    for (int k = 0; k < NCH; k++) begin
      if (fm[k]) begin
        tl_req.push_back(1'b0); tl_addr.push_back(32'h0); tl_zero.push_back(-1);
        for (int j = 0; j <= fw[f][k]; j++) begin
          tl_req.push_back(1'b1); tl_addr.push_back(addr[k]); tl_zero.push_back(-1);
        end
        fch.push_back(k); fwait.push_back(fw[f][k]); fdata.push_back(fd[f][k]);
      end else begin
        tl_req.push_back(1'b0); tl_addr.push_back(32'h0); tl_zero.push_back(k);
      end
    end
  endfunction

  task automatic setw(input int f, input int w0, input int w1, input int w2, input int w3);
    fw[f][0] = w0; fw[f][1] = w1; fw[f][2] = w2; fw[f][3] = w3;
  endtask

  task automatic setd(input int f, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    fd[f][0] = d0; fd[f][1] = d1; fd[f][2] = d2; fd[f][3] = d3;
  endtask

  // Starts at a negedge with lrclk low; redge>0 adds a second edge in that cycle (and a refetch frame).
  task automatic run_frame(input int redge, input int clr_at);
    int   total, fi, rc;
    logic er;
    tl_req.delete(); tl_addr.delete(); tl_zero.delete();
    fch.delete(); fwait.delete(); fdata.delete();
    for (int k = 0; k < NCH; k++) addr[k] = $urandom;
    i_chanActive = fm;
    add_frame(0);
    if (redge > 0) add_frame(1);
    total = tl_req.size();
    fi = 0; rc = 0;
    lrclk = 1'b1;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      er = (c <= total) ? tl_req[c-1] : 1'b0;
      chk("busy", {31'h0, o_busy}, {31'h0, (c <= total)});
      chk("req", {31'h0, o_memReq}, {31'h0, er});
      if (er) chk("addr", o_memAddr, tl_addr[c-1]);
      chk("overrun", {31'h0, o_overrun}, {31'h0, ov_exp});
      check_deltas("delta");
      if (c == 1) lrclk = 1'b0;
      if (redge > 0 && c == redge) lrclk = 1'b1;
      if (redge > 0 && c == redge + 1) lrclk = 1'b0;
      i_clearOverrun = (c == clr_at);
      if (redge > 0 && c == redge) ov_exp = 1'b1;
      else if (c == clr_at) ov_exp = 1'b0;
      if (c <= total && tl_zero[c-1] >= 0) cur_delta[tl_zero[c-1]] = 12'h000;
      if (er) begin
        if (rc == fwait[fi]) begin
          i_memAck = 1'b1; i_memData = fdata[fi];
          cur_delta[fch[fi]] = fdata[fi][11:0];
          fi++; rc = 0;
        end else begin
          i_memAck = 1'b0; i_memData = 16'($urandom); rc++;
        end
      end else begin
        i_memAck = 1'($urandom_range(0, 1)); i_memData = 16'($urandom);
      end
    end
    i_memAck = 1'b0; i_clearOverrun = 1'b0;
  endtask

  task automatic clear_ov();
    i_clearOverrun = 1'b1;
    @(negedge clk);
    i_clearOverrun = 1'b0;
    ov_exp = 1'b0;
    chk("overrun_clear", {31'h0, o_overrun}, {31'h0, ov_exp});
  endtask

  initial begin
    rst = 1'b0; lrclk = 1'b0; i_memAck = 1'b0; i_memData = 16'h0; i_clearOverrun = 1'b0;
    i_chanActive = 4'h0; fm = 4'h0; ov_exp = 1'b0;
    for (int k = 0; k < NCH; k++) begin addr[k] = 32'h0; cur_delta[k] = 12'h000; end
    setw(1, 0, 0, 0, 0); setd(1, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, o_memReq}, 32'h0);
    chk("rst_addr", o_memAddr, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_overrun", {31'h0, o_overrun}, 32'h0);
    check_deltas("rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All active, zero-wait, reference data set.
    fm = 4'hF; setw(0, 0, 0, 0, 0); setd(0, 16'h0ABC, 16'h0123, 16'h0FFF, 16'h0800);
    run_frame(0, 0);
    // Channel 1 acked after three wait cycles.
    setw(0, 0, 3, 0, 0); setd(0, 16'h0111, 16'h0222, 16'h0333, 16'h0444);
    run_frame(0, 0);
    // Preload 0x555 then a 0101 mask: channels 1 and 3 zeroed, 7-cycle sequence.
    setw(0, 0, 0, 0, 0); setd(0, 16'h0555, 16'h0555, 16'h0555, 16'h0555);
    run_frame(0, 0);
    fm = 4'b0101; setd(0, 16'h0A5A, 16'h0BBB, 16'h05A5, 16'h0CCC);
    run_frame(0, 0);
    // Second edge during a stalled channel-2 request; refetch follows.
    fm = 4'hF; setw(0, 0, 0, 5, 0); setd(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    setw(1, 0, 1, 0, 2); setd(1, 16'h0F01, 16'h0E02, 16'h0D03, 16'h0C04);
    run_frame(8, 0);
    clear_ov();
    // Edge and clear together: set wins.
    setw(0, 0, 0, 0, 0); setw(1, 0, 0, 0, 0);
    setd(1, 16'h0321, 16'h0654, 16'h0987, 16'h0CBA);
    run_frame(5, 5);
    clear_ov();
    // Upper data bits discarded.
    setd(0, 16'hF7FF, 16'hFFFF, 16'h8000, 16'h1234);
    run_frame(0, 0);

    for (int n = 0; n < 16; n++) begin
      fm = 4'($urandom);
      for (int k = 0; k < NCH; k++) begin
        fw[0][k] = $urandom_range(0, 3);
        fd[0][k] = 16'($urandom);
      end
      run_frame(0, 0);
    end

    // Reset during a request with lrclk held high through release.
    fm = 4'hF; i_chanActive = fm;
    for (int k = 0; k < NCH; k++) addr[k] = $urandom;
    lrclk = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'h0, o_memReq}, 32'h1);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NCH; k++) cur_delta[k] = 12'h000;
    ov_exp = 1'b0;
    chk("async_rst_req", {31'h0, o_memReq}, 32'h0);
    chk("async_rst_addr", o_memAddr, 32'h0);
    chk("async_rst_busy", {31'h0, o_busy}, 32'h0);
    chk("async_rst_overrun", {31'h0, o_overrun}, 32'h0);
    check_deltas("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("post_rst_req", {31'h0, o_memReq}, 32'h0);
      chk("post_rst_busy", {31'h0, o_busy}, 32'h0);
    end
    lrclk = 1'b0;
    @(negedge clk);
    setw(0, 1, 0, 2, 0); setd(0, 16'h0765, 16'h0432, 16'h0AAA, 16'h0FED);
    run_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
